// File: rtl/rsa_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_cmd_ctrl
//
// Command sequencer for the RSA accelerator wrapper. Decodes ARM command
// words, runs the ARM data-in / data-out handshakes, pulses the load strobes
// for the wrapper's operand registers, launches the Montgomery multiplier or
// the exponentiation engine, and reports completion and status back to ARM.
// There is no wide datapath here; only the control of the wrapper's operand
// and result registers.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   arm_to_fpga_cmd[31:0]      command word (opcode in [2:0], [31:3] must be 0)
//   arm_to_fpga_cmd_valid      command strobe (only honoured in IDLE)
//   fpga_to_arm_done           command complete, held until done_read
//   fpga_to_arm_done_read      ARM acknowledge of done
//   arm_to_fpga_data_valid/ready   ARM -> block operand handshake (RX)
//   fpga_to_arm_data_valid/ready   block -> ARM result handshake (TX)
//   ld_mod, ld_rsq, ld_exp     operand register load strobes (accept cycle)
//   mont_start, exp_start      one-cycle core launch pulses
//   mont_done, exp_done        core completion (level or pulse)
//   core_abort                 one-cycle pulse on watchdog expiry
//   result_sel                 0 = Montgomery result, 1 = exponentiation
//   err                        status of the last command (sticky until next)
//   leds[3:0]                  {err, state}
// ---------------------------------------------------------------------------
module rsa_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] arm_to_fpga_cmd,
    input  logic        arm_to_fpga_cmd_valid,
    output logic        fpga_to_arm_done,
    input  logic        fpga_to_arm_done_read,
    input  logic        arm_to_fpga_data_valid,
    output logic        arm_to_fpga_data_ready,
    output logic        fpga_to_arm_data_valid,
    input  logic        fpga_to_arm_data_ready,
    output logic        ld_mod,
    output logic        ld_rsq,
    output logic        ld_exp,
    output logic        mont_start,
    output logic        exp_start,
    input  logic        mont_done,
    input  logic        exp_done,
    output logic        core_abort,
    output logic        result_sel,
    output logic        err,
    output logic [3:0]  leds
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_TX    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0] OP_MONT  = 3'd1;
    localparam logic [2:0] OP_RMOD  = 3'd2;
    localparam logic [2:0] OP_RRSQ  = 3'd3;
    localparam logic [2:0] OP_REXP  = 3'd4;
    localparam logic [2:0] OP_WRITE = 3'd5;
    localparam logic [2:0] OP_EXP   = 3'd6;

    // Last count value reached before the watchdog gives up.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mstart_q, mstart_d;
    logic             estart_q, estart_d;
    logic             abort_q, abort_d;

    logic             cmd_legal;
    logic             core_done;

    // Opcodes 0 and 7 are unassigned; any upper bit set is also illegal.
    assign cmd_legal = (arm_to_fpga_cmd[31:3] == 29'd0) &&
                       (arm_to_fpga_cmd[2:0] != 3'd0) &&
                       (arm_to_fpga_cmd[2:0] != 3'd7);

    // Only the launched core is watched; the idle core's done is ignored.
    assign core_done = (op_q == OP_EXP) ? exp_done : mont_done;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        err_d    = err_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        mstart_d = 1'b0;
        estart_d = 1'b0;
        abort_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    op_d  = arm_to_fpga_cmd[2:0];
                    err_d = 1'b0;
                    if (!cmd_legal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        case (arm_to_fpga_cmd[2:0])
                            OP_RMOD, OP_RRSQ, OP_REXP: state_d = S_RX;
                            OP_MONT, OP_EXP:           state_d = S_START;
                            OP_WRITE:                  state_d = S_TX;
                            default:                   state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_RX: begin
                if (arm_to_fpga_data_valid) state_d = S_DONE;
            end
            S_START: begin
                // Start pulses are registered so they appear in the first
                // WAIT cycle, two cycles after the command strobe.
                mstart_d = (op_q == OP_MONT);
                estart_d = (op_q == OP_EXP);
                sel_d    = (op_q == OP_EXP);
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Done is tested first so it wins over a coincident timeout.
                if (core_done) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TX: begin
                if (fpga_to_arm_data_ready) state_d = S_DONE;
            end
            S_DONE: begin
                // Any command arriving alongside done_read is dropped.
                if (fpga_to_arm_done_read) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            err_q    <= 1'b0;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
            mstart_q <= 1'b0;
            estart_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            mstart_q <= mstart_d;
            estart_q <= estart_d;
            abort_q  <= abort_d;
        end
    end

    assign fpga_to_arm_done       = (state_q == S_DONE);
    assign arm_to_fpga_data_ready = (state_q == S_RX);
    assign fpga_to_arm_data_valid = (state_q == S_TX);

    // Load strobes fire only in the accepting cycle of the RX handshake.
    assign ld_mod = (state_q == S_RX) && arm_to_fpga_data_valid && (op_q == OP_RMOD);
    assign ld_rsq = (state_q == S_RX) && arm_to_fpga_data_valid && (op_q == OP_RRSQ);
    assign ld_exp = (state_q == S_RX) && arm_to_fpga_data_valid && (op_q == OP_REXP);

    assign mont_start = mstart_q;
    assign exp_start  = estart_q;
    assign core_abort = abort_q;
    assign result_sel = sel_q;
    assign err        = err_q;
    assign leds       = {err_q, state_q};

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rsa_cmd_ctrl
//
// Two instances: dut_a with the default watchdog (long compute runs) and
// dut_b with a 16-cycle watchdog (timeout cases). Only one is active at a
// time; the other is held in reset. Directed command tasks describe, cycle
// by cycle, what the active instance must present, derived from the command
// protocol (state numbers, latencies, strobes). A few literal latency/count
// expectations pin that description down.
// ---------------------------------------------------------------------------
module tb_rsa_cmd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, a_hold, b_hold;
    logic [31:0] cmd;
    logic        cmd_valid, done_read, din_valid, dout_ready, mont_done, exp_done;

    logic a_done, a_drdy, a_dval, a_ldm, a_ldr, a_lde, a_ms, a_es, a_ab, a_sel, a_err;
    logic b_done, b_drdy, b_dval, b_ldm, b_ldr, b_lde, b_ms, b_es, b_ab, b_sel, b_err;
    logic [3:0] a_leds, b_leds;

    logic rst_a, rst_b;
    assign rst_a = reset | a_hold;
    assign rst_b = reset | b_hold;

    rsa_cmd_ctrl dut_a (
        .clk(clk), .reset(rst_a),
        .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
        .fpga_to_arm_done(a_done), .fpga_to_arm_done_read(done_read),
        .arm_to_fpga_data_valid(din_valid), .arm_to_fpga_data_ready(a_drdy),
        .fpga_to_arm_data_valid(a_dval), .fpga_to_arm_data_ready(dout_ready),
        .ld_mod(a_ldm), .ld_rsq(a_ldr), .ld_exp(a_lde),
        .mont_start(a_ms), .exp_start(a_es),
        .mont_done(mont_done), .exp_done(exp_done),
        .core_abort(a_ab), .result_sel(a_sel), .err(a_err), .leds(a_leds)
    );

    rsa_cmd_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut_b (
        .clk(clk), .reset(rst_b),
        .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
        .fpga_to_arm_done(b_done), .fpga_to_arm_done_read(done_read),
        .arm_to_fpga_data_valid(din_valid), .arm_to_fpga_data_ready(b_drdy),
        .fpga_to_arm_data_valid(b_dval), .fpga_to_arm_data_ready(dout_ready),
        .ld_mod(b_ldm), .ld_rsq(b_ldr), .ld_exp(b_lde),
        .mont_start(b_ms), .exp_start(b_es),
        .mont_done(mont_done), .exp_done(exp_done),
        .core_abort(b_ab), .result_sel(b_sel), .err(b_err), .leds(b_leds)
    );

    // Observed vector: {done, drdy, dval, ldm, ldr, lde, ms, es, abort, sel, err, leds}
    logic        sel_b;
    logic [14:0] obs_a, obs_b, obs;
    assign obs_a = {a_done, a_drdy, a_dval, a_ldm, a_ldr, a_lde, a_ms, a_es, a_ab, a_sel, a_err, a_leds};
    assign obs_b = {b_done, b_drdy, b_dval, b_ldm, b_ldr, b_lde, b_ms, b_es, b_ab, b_sel, b_err, b_leds};
    assign obs   = sel_b ? obs_b : obs_a;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: running totals and timestamps, read by the main process.
    int n_ldm = 0, n_ldr = 0, n_lde = 0, n_ms = 0, n_es = 0, n_ab = 0;
    int n_dv = 0, n_rdy = 0, n_done = 0;
    int t_ms = 0, t_ab = 0, t_dr = 0, t_done = 0;
    logic prev_dr = 1'b0, prev_done = 1'b0, ab_led = 1'b0;
    always @(negedge clk) begin
        if (obs[11]) n_ldm++;
        if (obs[10]) n_ldr++;
        if (obs[9])  n_lde++;
        if (obs[8])  begin n_ms++; t_ms = cyc; end
        if (obs[7])  n_es++;
        if (obs[6])  begin n_ab++; t_ab = cyc; ab_led = obs[3]; end
        if (obs[12]) n_dv++;
        if (obs[13]) n_rdy++;
        if (obs[14]) n_done++;
        if (obs[13] && !prev_dr)   t_dr = cyc;
        if (obs[14] && !prev_done) t_done = cyc;
        prev_dr   = obs[13];
        prev_done = obs[14];
    end

    // Expected outputs for the current cycle.
    logic [2:0] e_state, e_op, e_ld;
    logic       e_err, e_sel, e_ms, e_es, e_abort, pre_rd;
    int         T;
    int         t_cmd, t_cd, t_wait;
    int         checks = 0, failures = 0;

    function automatic logic [14:0] expv();
        return {e_state == 3'd5, e_state == 3'd1, e_state == 3'd4, e_ld,
                e_ms, e_es, e_abort, e_sel, e_err, e_err, e_state};
    endfunction

    task automatic clr();
        e_ld = 3'b000; e_ms = 1'b0; e_es = 1'b0; e_abort = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int expd);
        checks++;
        if (act != expd) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expd);
        end
    endtask

    // Compare the active instance on the falling edge, then advance.
    task automatic tick();
        @(negedge clk);
        checks++;
        if (obs !== expv()) begin
            failures++;
            $display("FAIL cycle_cmp @%0d: outputs got %h expected %h", cyc, obs, expv());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clr(); e_state = 3'd0; tick();
        end
    endtask

    task automatic issue(input logic [31:0] c);
        logic legal;
        clr(); e_state = 3'd0;
        cmd = c; cmd_valid = 1'b1; t_cmd = cyc;
        tick();
        cmd_valid = 1'b0; cmd = 32'd0;
        legal = (c[31:3] == 29'd0) && (c[2:0] != 3'd0) && (c[2:0] != 3'd7);
        e_op  = c[2:0];
        e_err = !legal;
        if (!legal)                               e_state = 3'd5;
        else if (e_op >= 3'd2 && e_op <= 3'd4)    e_state = 3'd1;
        else if (e_op == 3'd1 || e_op == 3'd6)    e_state = 3'd2;
        else                                      e_state = 3'd4;
    endtask

    task automatic rx(input int dly);
        for (int k = 0; k <= dly; k++) begin
            clr(); e_state = 3'd1;
            din_valid = (k == dly);
            if (k == dly) begin
                e_ld = {e_op == 3'd2, e_op == 3'd3, e_op == 3'd4};
                done_read = pre_rd;
            end
            tick();
        end
        din_valid = 1'b0; clr(); e_state = 3'd5;
    endtask

    task automatic tx(input int dly);
        for (int k = 0; k <= dly; k++) begin
            clr(); e_state = 3'd4;
            dout_ready = (k == dly);
            tick();
        end
        dout_ready = 1'b0; clr(); e_state = 3'd5;
    endtask

    // START cycle then WAIT; core done after lat WAIT cycles (-1 = never).
    // The other core's done pulses at WAIT cycle 5 and must be ignored.
    task automatic compute(input int lat, input bit inject);
        logic core;
        clr(); e_state = 3'd2; tick();
        e_sel = (e_op == 3'd6); t_wait = cyc;
        for (int n = 0; n < T; n++) begin
            clr(); e_state = 3'd3;
            e_ms = (n == 0) && (e_op == 3'd1);
            e_es = (n == 0) && (e_op == 3'd6);
            core = (n == lat);
            if (e_op == 3'd6) begin exp_done = core; mont_done = (n == 5); end
            else              begin mont_done = core; exp_done = (n == 5); end
            if (core) t_cd = cyc;
            cmd_valid = inject && (n == 3);
            cmd       = (inject && n == 3) ? 32'd5 : 32'd0;
            tick();
            mont_done = 1'b0; exp_done = 1'b0; cmd_valid = 1'b0; cmd = 32'd0;
            if (core) begin clr(); e_state = 3'd5; break; end
            if (n == T - 1) begin clr(); e_state = 3'd5; e_abort = 1'b1; e_err = 1'b1; break; end
        end
    endtask

    task automatic done_ph(input int rd_dly, input bit drop);
        for (int k = 0; k <= rd_dly; k++) begin
            if (k > 0) clr();
            e_state   = 3'd5;
            done_read = (k == rd_dly);
            if (drop && k == rd_dly) begin cmd_valid = 1'b1; cmd = 32'd2; end
            tick();
        end
        done_read = 1'b0; cmd_valid = 1'b0; cmd = 32'd0;
        clr(); e_state = 3'd0;
    endtask

    int b0, b1, b2, b3, b4;

    initial begin
        reset = 1'b1; a_hold = 1'b0; b_hold = 1'b1; sel_b = 1'b0; T = 65535;
        cmd = 32'd0; cmd_valid = 1'b0; done_read = 1'b0; din_valid = 1'b0;
        dout_ready = 1'b0; mont_done = 1'b0; exp_done = 1'b0; pre_rd = 1'b0;
        e_state = 3'd0; e_op = 3'd0; e_err = 1'b0; e_sel = 1'b0; clr();

        tick();
        chk("reset_outputs", int'(obs), 0);
        tick();
        reset = 1'b0;
        idle(2);

        // WRITE before any compute: transfers, result_sel reads 0.
        b0 = n_dv;
        issue(32'd5);
        chk("write_init_sel", int'(obs[5]), 0);
        tx(0); done_ph(1, 1'b0); idle(1);
        chk("write_init_dv_cycles", n_dv - b0, 1);

        // Load modulus.
        b0 = n_ldm; b1 = n_ldr; b2 = n_lde;
        issue(32'd2); rx(0); done_ph(2, 1'b0); idle(1);
        chk("ld_mod_count", n_ldm - b0, 1);
        chk("ld_rsq_exp_count", (n_ldr - b1) + (n_lde - b2), 0);
        chk("rx_ready_latency", t_dr - t_cmd, 1);

        // R^2 with late data; exponent with done_read already high on entry.
        issue(32'd3); rx(2); done_ph(0, 1'b0); idle(1);
        b0 = n_done;
        pre_rd = 1'b1; issue(32'd4); rx(0); pre_rd = 1'b0;
        done_ph(0, 1'b0); idle(1);
        chk("done_min_one_cycle", n_done - b0, 1);

        // MONT, core done 40 cycles after start, stray WRITE during WAIT.
        b0 = n_ms; b1 = n_es; b2 = n_dv;
        issue(32'd1); compute(40, 1'b1); done_ph(0, 1'b0); idle(1);
        chk("mont_start_latency", t_ms - t_cmd, 2);
        chk("mont_start_count", n_ms - b0, 1);
        chk("mont_no_exp_start", n_es - b1, 0);
        chk("mont_done_latency", t_done - t_cd, 1);
        chk("wait_cmd_ignored", n_dv - b2, 0);

        // EXP (300 cycles) then WRITE with ready 3 cycles late.
        b0 = n_es; b1 = n_dv;
        issue(32'd6); compute(300, 1'b0); done_ph(0, 1'b0); idle(1);
        issue(32'd5); tx(3); done_ph(0, 1'b0); idle(1);
        chk("exp_start_count", n_es - b0, 1);
        chk("write_dv_cycles", n_dv - b1, 4);
        chk("result_sel_exp", int'(obs[5]), 1);

        // Illegal opcodes; second one's DONE also carries a dropped command.
        b0 = n_ldm + n_ldr + n_lde + n_ms + n_es; b1 = n_rdy;
        issue(32'd7); done_ph(1, 1'b0); idle(1);
        issue(32'h9); done_ph(0, 1'b1); idle(2);
        chk("illegal_no_strobes", n_ldm + n_ldr + n_lde + n_ms + n_es - b0, 0);
        chk("dropped_cmd_no_rx", n_rdy - b1, 0);
        chk("illegal_err_held", int'(obs[4]), 1);
        issue(32'd2); rx(0); done_ph(0, 1'b0); idle(1);
        chk("err_cleared", int'(obs[4]), 0);

        // Reset during RX, then a fresh command.
        b3 = n_ldr;
        issue(32'd3); clr(); e_state = 3'd1; tick();
        reset = 1'b1; din_valid = 1'b1; e_state = 3'd0; e_err = 1'b0; e_sel = 1'b0;
        tick(); tick();
        reset = 1'b0; din_valid = 1'b0; idle(1);
        chk("reset_rx_no_load", n_ldr - b3, 0);
        issue(32'd3); rx(1); done_ph(0, 1'b0); idle(1);
        chk("post_reset_load", n_ldr - b3, 1);

        // Switch to the short-watchdog instance.
        a_hold = 1'b1; b_hold = 1'b0; sel_b = 1'b1; T = 16;
        e_err = 1'b0; e_sel = 1'b0; idle(2);

        // Done on the last count: done wins.
        b4 = n_ab;
        issue(32'd1); compute(15, 1'b0); done_ph(0, 1'b0); idle(1);
        chk("done_beats_timeout", n_ab - b4, 0);
        chk("done_beats_timeout_err", int'(obs[4]), 0);

        // Core never finishes.
        issue(32'd1); compute(-1, 1'b0); done_ph(1, 1'b0); idle(1);
        chk("abort_count", n_ab - b4, 1);
        chk("abort_latency", t_ab - t_wait, 16);
        chk("abort_led_err", int'(ab_led), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_cmd_ctrl.md
Name: rsa_cmd_ctrl

Overview:
- Command sequencer for the RSA accelerator wrapper.
- Decodes ARM commands and runs the ARM data-in and data-out handshakes.
- Emits load strobes for the operand registers, launches the Montgomery multiplier or exponentiation engine, and raises done back to ARM.
- Contains no 1024-bit datapath. Operand and result registers live in the wrapper; this block drives only their control.

Parameters:
- TIMEOUT_CYCLES, 65535: maximum cycles to wait for core done before aborting.
- CNT_W, 16: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arm_to_fpga_cmd  in  32  command word; only bits [2:0] are decoded, bits [31:3] must be 0
- arm_to_fpga_cmd_valid  in  1  command strobe
- fpga_to_arm_done  out  1  command complete
- fpga_to_arm_done_read  in  1  ARM acknowledges done
- arm_to_fpga_data_valid  in  1  ARM input data valid
- arm_to_fpga_data_ready  out  1  block accepts input data
- fpga_to_arm_data_valid  out  1  result valid to ARM
- fpga_to_arm_data_ready  in  1  ARM ready for result
- ld_mod  out  1  load modulus register
- ld_rsq  out  1  load R^2 mod m (or A,B) register
- ld_exp  out  1  load {R mod m, exponent} register
- mont_start  out  1  one-cycle start pulse to Montgomery core
- exp_start  out  1  one-cycle start pulse to exponentiation engine
- mont_done  in  1  Montgomery core finished (level or pulse)
- exp_done  in  1  exponentiation finished (level or pulse)
- core_abort  out  1  one-cycle pulse on watchdog expiry
- result_sel  out  1  0 = Montgomery result, 1 = exponentiation result
- err  out  1  sticky status of the last command
- leds  out  4  {err, state[2:0]}

Behaviour:
- Reset state: IDLE, with every output 0. Reset mid-operation returns to IDLE immediately, with no done and no strobes.
- Command codes: 1 MONT, 2 READ_MOD, 3 READ_RSQ, 4 READ_EXP, 5 WRITE, 6 EXP. Any other value, or a nonzero cmd[31:3], is illegal.
- State encoding: IDLE=0, RX=1, START=2, WAIT=3, TX=4, DONE=5.
- IDLE:
  - On cmd_valid, latch the opcode and clear err.
  - Next state: 2/3/4 → RX; 1/6 → START; 5 → TX; illegal → DONE with err=1.
- RX:
  - arm_to_fpga_data_ready=1 for the whole state.
  - The cycle with data_valid=1 is the accepting cycle. In that cycle exactly one of ld_mod/ld_rsq/ld_exp is high (combinational: state==RX & data_valid & opcode match).
  - Next state DONE.
- START:
  - One cycle. mont_start=1 if opcode 1, exp_start=1 if opcode 6.
  - result_sel is registered here (0 for MONT, 1 for EXP) and holds until the next compute command.
  - Watchdog clears to 0. Next state WAIT.
- WAIT:
  - Only the done input of the launched core is observed; the other is ignored.
  - Done seen → DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYCLES-1 with no done: core_abort pulses for 1 cycle, err=1, next state DONE.
  - Done and timeout in the same cycle: done wins and err stays 0.
- TX:
  - fpga_to_arm_data_valid=1 until a cycle with data_ready=1 (transfer), then DONE.
  - WRITE before any compute since reset still transfers; result_sel reads 0.
- DONE:
  - fpga_to_arm_done=1, held until done_read=1, then IDLE on the next edge.
  - If done_read is already high on DONE entry, done is still high for at least 1 cycle.
- Command rules:
  - cmd_valid outside IDLE is ignored; the in-flight command is unaffected.
  - cmd_valid and done_read together in DONE: the command is dropped.
- Latency:
  - cmd_valid to RX entry: 1 cycle.
  - Data accept to done: 1 cycle.
  - MONT command to mont_start: 2 cycles.
  - Core done to fpga_to_arm_done: 1 cycle.
- err stays valid from DONE until the next accepted command.

Test Plan:
- Load mod: cmd=2, then data_valid=1 → data_ready high 1 cycle after cmd; ld_mod pulses exactly once; ld_rsq=ld_exp=0; done=1 until done_read; return to IDLE.
- MONT: cmd=1, model mont_done 40 cycles after mont_start → mont_start is one pulse 2 cycles after cmd; done 1 cycle after mont_done; result_sel=0; err=0; exp_start never high.
- EXP then WRITE: cmd=6 with exp_done after 300 cycles, then cmd=5 with data_ready asserted 3 cycles late → data_valid holds for those 3 cycles then drops; result_sel=1; done after the transfer.
- Timeout: TIMEOUT_CYCLES=16, cmd=1, mont_done never asserted → core_abort pulses exactly 16 cycles after entering WAIT; err=1; leds[3]=1; done asserted.
- Illegal cmd=7, then cmd=32'h9 → each gives done with err=1 and no strobes. A following cmd=2 clears err.
- Robustness: cmd_valid=1 with cmd=5 during WAIT is ignored (no data_valid). Asserting reset during RX → all outputs 0 on the following edge; block accepts a new cmd=3 after reset deasserts.
